// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: reset/NOP constants, FSM encoding and helpers.
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIssue   = 2'd0,
        StWait    = 2'd1,
        StDiscard = 2'd2,
        StHeld    = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Pipeline register between fetch and decode: reset > flush > hold > load > bubble.
module fetch_stage_if_id_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid    <= 1'b0;
            inst     <= NOP_INST;
            pc       <= 32'h0;
            pc_plus4 <= 32'h0;
        end else if (flush) begin
            valid <= 1'b0;
            inst  <= NOP_INST;
        end else if (!hold) begin
            if (load) begin
                valid    <= 1'b1;
                inst     <= load_inst;
                pc       <= load_pc;
                pc_plus4 <= load_pc + 32'd4;
            end else begin
                valid <= 1'b0;
                inst  <= NOP_INST;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem request FSM, 1-entry skid buffer and IF/ID.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  fpc_q;
    logic [31:0]  skid_inst_q;
    logic [31:0]  skid_pc_q;

    logic         accept;
    logic [31:0]  target;
    logic         load;
    logic [31:0]  load_inst;
    logic [31:0]  load_pc;
    logic         hold;

    assign imem_req  = (state_q == StIssue) & ~redirect_valid & reset_n;
    assign imem_addr = pc_q;
    assign accept    = imem_req & imem_ready;
    assign target    = word_align(redirect_pc);

    // Holding an empty register is the same as a bubble, so a stall only
    // blocks the load when decode already owns a live instruction.
    assign hold = stall & id_valid;

    always_comb begin
        load      = 1'b0;
        load_inst = imem_rdata;
        load_pc   = fpc_q;
        if (!redirect_valid) begin
            if (state_q == StWait && imem_rvalid && (!stall || !id_valid)) begin
                load = 1'b1;
            end else if (state_q == StHeld && !stall) begin
                load      = 1'b1;
                load_inst = skid_inst_q;
                load_pc   = skid_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIssue;
            pc_q        <= RESET_PC;
            fpc_q       <= 32'h0;
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= 32'h0;
        end else begin
            case (state_q)
                StIssue: begin
                    if (redirect_valid) begin
                        pc_q <= target;
                    end else if (accept) begin
                        fpc_q   <= pc_q;
                        pc_q    <= pc_q + 32'd4;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid) begin
                        if (redirect_valid) begin
                            pc_q    <= target;
                            state_q <= StIssue;
                        end else if (!stall || !id_valid) begin
                            state_q <= StIssue;
                        end else begin
                            skid_inst_q <= imem_rdata;
                            skid_pc_q   <= fpc_q;
                            state_q     <= StHeld;
                        end
                    end else if (redirect_valid) begin
                        pc_q    <= target;
                        state_q <= StDiscard;
                    end
                end
                StDiscard: begin
                    if (redirect_valid) begin
                        pc_q <= target;
                    end
                    if (imem_rvalid) begin
                        state_q <= StIssue;
                    end
                end
                StHeld: begin
                    if (redirect_valid) begin
                        pc_q        <= target;
                        skid_inst_q <= NOP_INST;
                        state_q     <= StIssue;
                    end else if (!stall) begin
                        state_q <= StIssue;
                    end
                end
                default: state_q <= StIssue;
            endcase
        end
    end

    fetch_stage_if_id_reg #(
        .NOP_INST(NOP_INST)
    ) u_if_id_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (redirect_valid),
        .hold     (hold),
        .load     (load),
        .load_inst(load_inst),
        .load_pc  (load_pc),
        .valid    (id_valid),
        .inst     (id_inst),
        .pc       (id_pc),
        .pc_plus4 (id_pc_plus4)
    );

endmodule
